simon_round_ctrl: RTL and testbench

SIMON_ROUND_CTRL -- requirements
Module: simon_round_ctrl

---
 rtl/simon_round_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_simon_round_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_round_ctrl.sv
// Round controller for a Simon-style memory game: grows a symbol sequence, replays it
// on the LEDs, checks the player's switch toggles and reports pass/fail/win on HEX.
module simon_round_ctrl #(
    parameter int MAX_LEN       = 8,
    parameter int TIMEOUT_TICKS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic [2:0] rand_num,
    input  logic       sw_event,
    input  logic [2:0] sw_index,
    output logic [7:0] LED,
    output logic [6:0] HEX,
    output logic [3:0] level,
    output logic       busy
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_APPEND   = 3'd1;
    localparam logic [2:0] S_SHOW_ON  = 3'd2;
    localparam logic [2:0] S_SHOW_OFF = 3'd3;
    localparam logic [2:0] S_WAIT_IN  = 3'd4;
    localparam logic [2:0] S_PASS     = 3'd5;
    localparam logic [2:0] S_FAIL     = 3'd6;
    localparam logic [2:0] S_WIN      = 3'd7;

    localparam logic [6:0] HEX_ONE   = 7'b1111001;
    localparam logic [6:0] HEX_ZERO  = 7'b1000000;
    localparam logic [6:0] HEX_BLANK = 7'b1111111;

    localparam logic [3:0] LEN_MAX = 4'(MAX_LEN);
    localparam logic [3:0] TO_LAST = 4'(TIMEOUT_TICKS - 1);

    logic [2:0] state_q, state_d;
    logic [3:0] level_q, level_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] to_cnt_q, to_cnt_d;
    logic [7:0] led_q, led_d;
    logic [6:0] hex_q, hex_d;

    logic [2:0] seq_q [8];
    logic       seq_we;
    logic [2:0] seq_waddr;
    logic [2:0] seq_wdata;

    logic [2:0] cur_sym;
    logic       at_last;
    logic       game_over;

    assign cur_sym   = seq_q[idx_q];
    assign at_last   = ({1'b0, idx_q} == (level_q - 4'd1));
    assign game_over = (state_q == S_IDLE) || (state_q == S_FAIL) || (state_q == S_WIN);

    // The first symbol of every game is fixed; later ones come from the LFSR.
    assign seq_waddr = level_q[2:0] - 3'd1;
    assign seq_wdata = (level_q == 4'd1) ? 3'd5 : rand_num;

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        idx_d    = idx_q;
        to_cnt_d = to_cnt_q;
        led_d    = led_q;
        hex_d    = hex_q;
        seq_we   = 1'b0;

        if (game_over && start) begin
            level_d  = 4'd1;
            idx_d    = 3'd0;
            to_cnt_d = 4'd0;
            led_d    = 8'h00;
            hex_d    = HEX_BLANK;
            state_d  = S_APPEND;
        end else begin
            case (state_q)
                S_APPEND: begin
                    seq_we  = 1'b1;
                    idx_d   = 3'd0;
                    state_d = S_SHOW_ON;
                end
                S_SHOW_ON: begin
                    if (tick) begin
                        led_d   = 8'h00;
                        state_d = S_SHOW_OFF;
                    end else begin
                        led_d = 8'd1 << cur_sym;
                    end
                end
                S_SHOW_OFF: begin
                    if (tick) begin
                        if (at_last) begin
                            idx_d    = 3'd0;
                            to_cnt_d = 4'd0;
                            state_d  = S_WAIT_IN;
                        end else begin
                            idx_d   = idx_q + 3'd1;
                            state_d = S_SHOW_ON;
                        end
                    end
                end
                S_WAIT_IN: begin
                    // A switch toggle wins over a coincident tick.
                    if (sw_event) begin
                        if (sw_index == cur_sym) begin
                            to_cnt_d = 4'd0;
                            if (at_last) begin
                                state_d = S_PASS;
                            end else begin
                                idx_d = idx_q + 3'd1;
                            end
                        end else begin
                            state_d = S_FAIL;
                        end
                    end else if (tick) begin
                        to_cnt_d = to_cnt_q + 4'd1;
                        if (to_cnt_q == TO_LAST) begin
                            state_d = S_FAIL;
                        end
                    end
                end
                S_PASS: begin
                    if (tick) begin
                        hex_d = HEX_BLANK;
                        if (level_q == LEN_MAX) begin
                            state_d = S_WIN;
                        end else begin
                            level_d = level_q + 4'd1;
                            state_d = S_APPEND;
                        end
                    end else begin
                        hex_d = HEX_ONE;
                    end
                end
                S_FAIL: begin
                    hex_d = HEX_ZERO;
                    led_d = 8'h00;
                end
                S_WIN: begin
                    hex_d = HEX_ONE;
                    led_d = 8'hFF;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            level_q  <= 4'd1;
            idx_q    <= 3'd0;
            to_cnt_q <= 4'd0;
            led_q    <= 8'h00;
            hex_q    <= HEX_BLANK;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            idx_q    <= idx_d;
            to_cnt_q <= to_cnt_d;
            led_q    <= led_d;
            hex_q    <= hex_d;
        end
    end

    // Sequence storage is never cleared; only entries below level are ever read.
    always_ff @(posedge clk) begin
        if (seq_we && !rst) begin
            seq_q[seq_waddr] <= seq_wdata;
        end
    end

    assign LED   = led_q;
    assign HEX   = hex_q;
    assign level = level_q;
    assign busy  = !game_over;

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Bench for simon_round_ctrl: directed vector table, a MAX_LEN=2 win sequence and
// randomized games checked against a queue-based model of the game rules.
module tb_simon_round_ctrl;

    localparam int ML = 8;
    localparam int TO = 5;
    localparam logic [6:0] HB = 7'b1111111;
    localparam logic [6:0] H1 = 7'b1111001;
    localparam logic [6:0] H0 = 7'b1000000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic [2:0] rand_num = 3'd0;
    logic       sw_event = 1'b0;
    logic [2:0] sw_index = 3'd0;

    logic [7:0] led, led2;
    logic [6:0] hex, hex2;
    logic [3:0] lvl, lvl2;
    logic       bsy, bsy2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    simon_round_ctrl #(.MAX_LEN(ML), .TIMEOUT_TICKS(TO)) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .rand_num(rand_num),
        .sw_event(sw_event), .sw_index(sw_index),
        .LED(led), .HEX(hex), .level(lvl), .busy(bsy)
    );

    simon_round_ctrl #(.MAX_LEN(2), .TIMEOUT_TICKS(TO)) dut2 (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .rand_num(rand_num),
        .sw_event(sw_event), .sw_index(sw_index),
        .LED(led2), .HEX(hex2), .level(lvl2), .busy(bsy2)
    );

    typedef struct {
        logic       rst, start, tick, sw;
        logic [2:0] sidx, rnd;
        logic [7:0] led;
        logic [6:0] hex;
        logic [3:0] lvl;
        logic       bsy;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t v(logic r, logic s, logic t, logic w, logic [2:0] si,
                               logic [2:0] rn, logic [7:0] l, logic [6:0] h,
                               logic [3:0] lv, logic b);
        vec_t x;
        x.rst = r; x.start = s; x.tick = t; x.sw = w; x.sidx = si; x.rnd = rn;
        x.led = l; x.hex = h; x.lvl = lv; x.bsy = b;
        return x;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // One active clock edge with the currently driven inputs; pulses drop afterwards.
    task automatic step();
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0; tick = 1'b0; sw_event = 1'b0;
    endtask

    task automatic play_game(input int fail_round, input int fail_kind);
        logic [2:0] sq [$];
        int fidx;
        rand_num = 3'($urandom);
        start = 1'b1; step();
        chk("g_start_busy", 8'(bsy), 8'd1);
        chk("g_start_level", 8'(lvl), 8'd1);
        chk("g_start_hex", 8'(hex), 8'(HB));
        for (int L = 1; L <= ML; L++) begin
            sq.push_back((L == 1) ? 3'd5 : rand_num);
            step();
            for (int i = 0; i < L; i++) begin
                step();
                repeat ($urandom_range(0, 2)) begin
                    if ($urandom_range(0, 2) == 0) begin
                        sw_event = 1'b1; sw_index = 3'($urandom);
                    end
                    if ($urandom_range(0, 3) == 0) start = 1'b1;
                    step();
                end
                chk("g_show_led", led, 8'd1 << sq[i]);
                chk("g_show_level", 8'(lvl), 8'(L));
                chk("g_show_busy", 8'(bsy), 8'd1);
                tick = 1'b1; step();
                chk("g_off_led", led, 8'h00);
                repeat ($urandom_range(0, 2)) step();
                tick = 1'b1; step();
            end
            fidx = $urandom_range(0, L - 1);
            for (int i = 0; i < L; i++) begin
                if (L == fail_round && i == fidx) begin
                    if (fail_kind == 0) begin
                        sw_event = 1'b1;
                        sw_index = sq[i] + 3'($urandom_range(1, 7));
                        step();
                    end else begin
                        repeat (TO - 1) begin tick = 1'b1; step(); end
                        chk("g_pre_timeout_busy", 8'(bsy), 8'd1);
                        tick = 1'b1; step();
                    end
                    chk("g_fail_busy", 8'(bsy), 8'd0);
                    step();
                    chk("g_fail_hex", 8'(hex), 8'(H0));
                    chk("g_fail_led", led, 8'h00);
                    sw_event = 1'b1; sw_index = sq[i]; step();
                    chk("g_fail_hold_hex", 8'(hex), 8'(H0));
                    chk("g_fail_hold_level", 8'(lvl), 8'(L));
                    return;
                end
                repeat ($urandom_range(0, TO - 1)) begin tick = 1'b1; step(); end
                chk("g_wait_busy", 8'(bsy), 8'd1);
                sw_event = 1'b1; sw_index = sq[i];
                tick = ($urandom_range(0, 1) == 1);
                step();
            end
            chk("g_pass_busy", 8'(bsy), 8'd1);
            step();
            chk("g_pass_hex", 8'(hex), 8'(H1));
            rand_num = 3'($urandom);
            tick = 1'b1; step();
            chk("g_pass_clear", 8'(hex), 8'(HB));
            if (L == ML) begin
                chk("g_win_busy", 8'(bsy), 8'd0);
                step();
                chk("g_win_led", led, 8'hFF);
                chk("g_win_hex", 8'(hex), 8'(H1));
                return;
            end
            chk("g_next_level", 8'(lvl), 8'(L + 1));
        end
    endtask

    initial begin
        //         rst st tk sw sidx rnd   led    hex lvl bsy
        tbl.push_back(v(1, 0, 0, 0, 0, 3, 8'h00, HB, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 3, 8'h00, HB, 1, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 3, 8'h00, HB, 1, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 3, 8'h00, HB, 1, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 3, 8'h20, HB, 1, 1));
        tbl.push_back(v(0, 0, 0, 1, 5, 3, 8'h20, HB, 1, 1));
        tbl.push_back(v(0, 1, 0, 0, 5, 3, 8'h20, HB, 1, 1));
        tbl.push_back(v(0, 0, 1, 0, 5, 3, 8'h00, HB, 1, 1));
        tbl.push_back(v(0, 0, 0, 0, 5, 3, 8'h00, HB, 1, 1));
        tbl.push_back(v(0, 0, 1, 0, 5, 3, 8'h00, HB, 1, 1));
        tbl.push_back(v(0, 0, 1, 0, 5, 3, 8'h00, HB, 1, 1));
        tbl.push_back(v(0, 0, 1, 1, 5, 3, 8'h00, HB, 1, 1));
        tbl.push_back(v(0, 0, 0, 0, 5, 3, 8'h00, H1, 1, 1));
        tbl.push_back(v(0, 0, 1, 0, 5, 6, 8'h00, HB, 2, 1));
        tbl.push_back(v(0, 0, 0, 0, 5, 6, 8'h00, HB, 2, 1));
        tbl.push_back(v(0, 0, 0, 0, 5, 6, 8'h20, HB, 2, 1));
        tbl.push_back(v(0, 0, 1, 0, 5, 6, 8'h00, HB, 2, 1));
        tbl.push_back(v(0, 0, 1, 0, 5, 6, 8'h00, HB, 2, 1));
        tbl.push_back(v(0, 0, 0, 0, 5, 6, 8'h40, HB, 2, 1));
        tbl.push_back(v(0, 0, 1, 0, 5, 6, 8'h00, HB, 2, 1));
        tbl.push_back(v(0, 0, 1, 0, 5, 6, 8'h00, HB, 2, 1));
        tbl.push_back(v(0, 0, 0, 1, 5, 6, 8'h00, HB, 2, 1));
        tbl.push_back(v(0, 0, 0, 1, 2, 6, 8'h00, HB, 2, 0));
        tbl.push_back(v(0, 0, 0, 0, 2, 6, 8'h00, H0, 2, 0));
        tbl.push_back(v(0, 0, 0, 1, 6, 6, 8'h00, H0, 2, 0));
        tbl.push_back(v(0, 0, 1, 0, 6, 6, 8'h00, H0, 2, 0));
        tbl.push_back(v(0, 1, 0, 0, 6, 6, 8'h00, HB, 1, 1));
        tbl.push_back(v(0, 0, 0, 0, 6, 6, 8'h00, HB, 1, 1));
        tbl.push_back(v(0, 0, 0, 0, 6, 6, 8'h20, HB, 1, 1));
        tbl.push_back(v(0, 0, 1, 0, 6, 6, 8'h00, HB, 1, 1));
        tbl.push_back(v(0, 0, 1, 0, 6, 6, 8'h00, HB, 1, 1));
        tbl.push_back(v(0, 0, 1, 0, 6, 6, 8'h00, HB, 1, 1));
        tbl.push_back(v(0, 0, 1, 0, 6, 6, 8'h00, HB, 1, 1));
        tbl.push_back(v(0, 0, 1, 0, 6, 6, 8'h00, HB, 1, 1));
        tbl.push_back(v(0, 0, 1, 0, 6, 6, 8'h00, HB, 1, 1));
        tbl.push_back(v(0, 0, 1, 0, 6, 6, 8'h00, HB, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 6, 6, 8'h00, H0, 1, 0));
        tbl.push_back(v(0, 1, 0, 0, 6, 6, 8'h00, HB, 1, 1));
        tbl.push_back(v(0, 0, 0, 0, 6, 6, 8'h00, HB, 1, 1));
        tbl.push_back(v(0, 0, 0, 0, 6, 6, 8'h20, HB, 1, 1));
        tbl.push_back(v(1, 1, 1, 1, 5, 6, 8'h00, HB, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 5, 6, 8'h00, HB, 1, 0));

        foreach (tbl[n]) begin
            rst = tbl[n].rst; start = tbl[n].start; tick = tbl[n].tick;
            sw_event = tbl[n].sw; sw_index = tbl[n].sidx; rand_num = tbl[n].rnd;
            step();
            chk($sformatf("tbl_led[%0d]", n), led, tbl[n].led);
            chk($sformatf("tbl_hex[%0d]", n), 8'(hex), 8'(tbl[n].hex));
            chk($sformatf("tbl_level[%0d]", n), 8'(lvl), 8'(tbl[n].lvl));
            chk($sformatf("tbl_busy[%0d]", n), 8'(bsy), 8'(tbl[n].bsy));
        end

        // Two-round game to a win on the MAX_LEN=2 instance.
        rand_num = 3'd3;
        start = 1'b1; step();
        chk("w_start_busy", 8'(bsy2), 8'd1);
        step();
        step();
        chk("w_show1_led", led2, 8'h20);
        tick = 1'b1; step();
        tick = 1'b1; step();
        sw_event = 1'b1; sw_index = 3'd5; step();
        step();
        chk("w_pass1_hex", 8'(hex2), 8'(H1));
        tick = 1'b1; step();
        chk("w_level2", 8'(lvl2), 8'd2);
        chk("w_pass1_clear", 8'(hex2), 8'(HB));
        step();
        step();
        chk("w_show2a_led", led2, 8'h20);
        tick = 1'b1; step();
        tick = 1'b1; step();
        step();
        chk("w_show2b_led", led2, 8'h08);
        tick = 1'b1; step();
        tick = 1'b1; step();
        sw_event = 1'b1; sw_index = 3'd5; step();
        sw_event = 1'b1; sw_index = 3'd3; step();
        step();
        chk("w_pass2_hex", 8'(hex2), 8'(H1));
        tick = 1'b1; step();
        chk("w_win_busy", 8'(bsy2), 8'd0);
        step();
        chk("w_win_led", led2, 8'hFF);
        chk("w_win_hex", 8'(hex2), 8'(H1));
        chk("w_win_level", 8'(lvl2), 8'd2);
        start = 1'b1; step();
        chk("w_restart_level", 8'(lvl2), 8'd1);
        chk("w_restart_led", led2, 8'h00);
        chk("w_restart_hex", 8'(hex2), 8'(HB));

        rst = 1'b1; step();
        play_game(ML + 1, 0);
        play_game(3, 0);
        play_game(2, 1);
        for (int g = 0; g < 6; g++) begin
            play_game($urandom_range(1, ML + 1), $urandom_range(0, 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
